uart_if_nbyte: RTL and testbench

Parametrised UART word interface: a full-duplex 8N1 serial port that assembles WORD_BYTES received bytes into one parallel word and serialises parallel words back out, byte by byte. It extends the fixed 16-bit UART interface with the following:
- configurable word width and byte order;
- an inter-byte timeout that discards partial words;
- framing-error reporting;
- a ready/valid transmit handshake;
- optional loopback mode.

It sits between the board rxd/txd pins and the register/command logic.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_byte_rx.sv | 113 +++++++++++
 rtl/uart_if_nbyte.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_if_nbyte.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART word interface.
// Both the byte receiver and the word-level top import this package.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // Counter width for values 0..value-1. It is never below 1, so that
   // single-entry counters stay legal.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rxd synchroniser, start-glitch rejection, mid-bit sampling and stop check.
// A bad stop bit parks the FSM in RX_BREAK until the line has idled high for one full bit-time.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 108
) (
   input  logic                 clk_i,
   input  logic                 rstb_i,
   input  logic                 rxd_i,
   output logic [DATA_BITS-1:0] rxByte_o,
   output logic                 byteValid_o,
   output logic                 frameErr_o,
   output logic                 startEdge_o
);

   localparam int CW = clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

   logic rxMeta_q, rxSync_q, rxPrev_q;
   rx_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bitIdx_q, bitIdx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;

   always_ff @(posedge clk_i or negedge rstb_i) begin
      if (!rstb_i) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
         state_q  <= RX_IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
      end else begin
         rxMeta_q <= rxd_i;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
      end
   end

   // Data bits arrive LSB first, so each new bit shifts in from the top.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitIdx_d    = bitIdx_q;
      shift_d     = shift_q;
      byteValid_o = 1'b0;
      frameErr_o  = 1'b0;
      startEdge_o = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            if (rxPrev_q && !rxSync_q) begin
               state_d     = RX_START;
               cnt_d       = '0;
               startEdge_o = 1'b1;
            end
         end
         RX_START: begin
            if (cnt_q == HALF_END) begin
               cnt_d    = '0;
               bitIdx_d = '0;
               state_d  = rxSync_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d    = '0;
               shift_d  = {rxSync_q, shift_q[DATA_BITS-1:1]};
               bitIdx_d = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) state_d = RX_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (rxSync_q) begin
                  byteValid_o = 1'b1;
                  state_d     = RX_IDLE;
               end else begin
                  frameErr_o = 1'b1;
                  state_d    = RX_BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_BREAK: begin
            if (!rxSync_q) begin
               cnt_d = '0;
            end else if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign rxByte_o = shift_q;

endmodule

// File: rtl/uart_if_nbyte.sv
// UART word interface: packs WORD_BYTES received bytes into a word, drops stale partial words
// after an idle timeout, serialises words byte by byte, and can echo received words back out.
module uart_if_nbyte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 108,
   parameter int WORD_BYTES   = 2,
   parameter int MSB_FIRST    = 1,
   parameter int TIMEOUT_BITS = 8,
   parameter int LOOPBACK     = 0
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    rxd,
   output logic                    txd,
   output logic [8*WORD_BYTES-1:0] rx_word,
   output logic                    rx_valid,
   output logic                    frame_err,
   input  logic [8*WORD_BYTES-1:0] tx_word,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic                    overrun
);

   localparam int W   = DATA_BITS * WORD_BYTES;
   localparam int BCW = clog2(WORD_BYTES + 1);
   localparam int BYW = clog2(WORD_BYTES);
   localparam int CW  = clog2(CLKS_PER_BIT);
   localparam int TOW = clog2(TIMEOUT_BITS * CLKS_PER_BIT);
   localparam logic [CW-1:0]  BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [TOW-1:0] TO_END  = TOW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

   logic [DATA_BITS-1:0] rxByte;
   logic byteValid, frameErrRaw, startEdge;

   uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_rx (
      .clk_i       (clk),
      .rstb_i      (rstb),
      .rxd_i       (rxd),
      .rxByte_o    (rxByte),
      .byteValid_o (byteValid),
      .frameErr_o  (frameErrRaw),
      .startEdge_o (startEdge)
   );

   logic [BCW-1:0] byteCount_q, byteCount_d;
   logic [W-1:0] asm_q, asm_d, asmWord, rxWord_q, rxWord_d;
   logic rxValid_q, rxValid_d, frameErr_q, frameErr_d;
   logic toActive_q, toActive_d;
   logic [TOW-1:0] toCnt_q, toCnt_d;
   logic wordDone;
   int slot;

   always_comb begin
      slot = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - int'(byteCount_q)) : int'(byteCount_q);
      asmWord = asm_q;
      for (int i = 0; i < WORD_BYTES; i++) begin
         if (i == slot) asmWord[i*DATA_BITS +: DATA_BITS] = rxByte;
      end
   end

   assign wordDone = byteValid && (byteCount_q == BCW'(WORD_BYTES - 1));

   // A start edge is checked before expiry so that it wins a same-cycle race.
   always_comb begin
      byteCount_d = byteCount_q;
      asm_d       = asm_q;
      rxWord_d    = rxWord_q;
      rxValid_d   = 1'b0;
      frameErr_d  = 1'b0;
      toActive_d  = toActive_q;
      toCnt_d     = toCnt_q;
      if (toActive_q) begin
         if (startEdge) begin
            toActive_d = 1'b0;
         end else if (toCnt_q == TO_END) begin
            toActive_d  = 1'b0;
            byteCount_d = '0;
         end else begin
            toCnt_d = toCnt_q + 1'b1;
         end
      end
      if (frameErrRaw) begin
         byteCount_d = '0;
         frameErr_d  = 1'b1;
         toActive_d  = 1'b0;
      end else if (byteValid) begin
         if (wordDone) begin
            rxWord_d    = asmWord;
            rxValid_d   = 1'b1;
            byteCount_d = '0;
            toActive_d  = 1'b0;
         end else begin
            asm_d       = asmWord;
            byteCount_d = byteCount_q + 1'b1;
            toActive_d  = 1'b1;
            toCnt_d     = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         byteCount_q <= '0;
         asm_q       <= '0;
         rxWord_q    <= '0;
         rxValid_q   <= 1'b0;
         frameErr_q  <= 1'b0;
         toActive_q  <= 1'b0;
         toCnt_q     <= '0;
      end else begin
         byteCount_q <= byteCount_d;
         asm_q       <= asm_d;
         rxWord_q    <= rxWord_d;
         rxValid_q   <= rxValid_d;
         frameErr_q  <= frameErr_d;
         toActive_q  <= toActive_d;
         toCnt_q     <= toCnt_d;
      end
   end

   tx_state_t txState_q, txState_d;
   logic [CW-1:0] txCnt_q, txCnt_d;
   logic [2:0] txBit_q, txBit_d;
   logic [BYW-1:0] txByteIdx_q, txByteIdx_d;
   logic [DATA_BITS-1:0] txByte_q, txByte_d;
   logic [W-1:0] txWord_q, txWord_d, txReqWord;
   logic txd_q, txd_d, txIdle, txReq;

   function automatic logic [DATA_BITS-1:0] firstByte(input logic [W-1:0] w);
      return (MSB_FIRST != 0) ? w[W-1 -: DATA_BITS] : w[DATA_BITS-1:0];
   endfunction

   function automatic logic [W-1:0] nextWord(input logic [W-1:0] w);
      return (MSB_FIRST != 0) ? (w << DATA_BITS) : (w >> DATA_BITS);
   endfunction

   assign txIdle    = (txState_q == TX_IDLE);
   assign txReq     = (LOOPBACK != 0) ? rxValid_q : tx_valid;
   assign txReqWord = (LOOPBACK != 0) ? rxWord_q : tx_word;

   // txd is registered from the next state so the pin never glitches between bits.
   always_comb begin
      txState_d   = txState_q;
      txCnt_d     = txCnt_q;
      txBit_d     = txBit_q;
      txByteIdx_d = txByteIdx_q;
      txByte_d    = txByte_q;
      txWord_d    = txWord_q;
      txd_d       = txd_q;
      unique case (txState_q)
         TX_IDLE: begin
            if (txReq) begin
               txByte_d    = firstByte(txReqWord);
               txWord_d    = nextWord(txReqWord);
               txByteIdx_d = '0;
               txCnt_d     = '0;
               txd_d       = 1'b0;
               txState_d   = TX_START;
            end
         end
         TX_START: begin
            if (txCnt_q == BIT_END) begin
               txCnt_d   = '0;
               txBit_d   = '0;
               txd_d     = txByte_q[0];
               txState_d = TX_DATA;
            end else begin
               txCnt_d = txCnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (txCnt_q == BIT_END) begin
               txCnt_d  = '0;
               txByte_d = txByte_q >> 1;
               txBit_d  = txBit_q + 3'd1;
               if (txBit_q == 3'd7) begin
                  txd_d     = 1'b1;
                  txState_d = TX_STOP;
               end else begin
                  txd_d = txByte_q[1];
               end
            end else begin
               txCnt_d = txCnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (txCnt_q == BIT_END) begin
               txCnt_d = '0;
               if (txByteIdx_q == BYW'(WORD_BYTES - 1)) begin
                  txd_d     = 1'b1;
                  txState_d = TX_IDLE;
               end else begin
                  txByteIdx_d = txByteIdx_q + 1'b1;
                  txByte_d    = firstByte(txWord_q);
                  txWord_d    = nextWord(txWord_q);
                  txd_d       = 1'b0;
                  txState_d   = TX_START;
               end
            end else begin
               txCnt_d = txCnt_q + 1'b1;
            end
         end
         default: txState_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         txState_q   <= TX_IDLE;
         txCnt_q     <= '0;
         txBit_q     <= '0;
         txByteIdx_q <= '0;
         txByte_q    <= '0;
         txWord_q    <= '0;
         txd_q       <= 1'b1;
      end else begin
         txState_q   <= txState_d;
         txCnt_q     <= txCnt_d;
         txBit_q     <= txBit_d;
         txByteIdx_q <= txByteIdx_d;
         txByte_q    <= txByte_d;
         txWord_q    <= txWord_d;
         txd_q       <= txd_d;
      end
   end

   assign txd       = txd_q;
   assign tx_ready  = txIdle;
   assign rx_word   = rxWord_q;
   assign rx_valid  = rxValid_q;
   assign frame_err = frameErr_q;
   assign overrun   = (LOOPBACK != 0) && rxValid_q && !txIdle;

endmodule

// File: tb/tb_uart_if_nbyte.sv
// Scoreboard bench for uart_if_nbyte: MSB-first, LSB-first and loopback instances share one clock.
// Expected words/bytes are queued as stimulus is issued; monitors pop them as the DUTs respond.
module tb_uart_if_nbyte;

   localparam int BIT = 108;

   logic clk, rstb;
   logic rxdMain, rxdLoop;
   logic txValid;
   logic [15:0] txWord;
   bit txCheckOn;

   logic txdMsb, rxValidMsb, feMsb, txReadyMsb, ovrMsb;
   logic [15:0] rxWordMsb;
   logic txdLsb, rxValidLsb, feLsb, txReadyLsb, ovrLsb;
   logic [15:0] rxWordLsb;
   logic txdLoop, rxValidLoop, feLoop, txReadyLoop, ovrLoop;
   logic [7:0] rxWordLoop;

   int errors, checks;
   int feCountMsb, feCountLsb, ovrCountLoop, ovrCountMsb;
   logic [15:0] expMsbQ[$], expLsbQ[$];
   logic [7:0] expLoopRxQ[$], expTxQ[$], expLoopTxQ[$];

   uart_if_nbyte #(.CLKS_PER_BIT(BIT), .WORD_BYTES(2), .MSB_FIRST(1), .TIMEOUT_BITS(8), .LOOPBACK(0)) dutMsb (
      .clk(clk), .rstb(rstb), .rxd(rxdMain), .txd(txdMsb), .rx_word(rxWordMsb), .rx_valid(rxValidMsb),
      .frame_err(feMsb), .tx_word(txWord), .tx_valid(txValid), .tx_ready(txReadyMsb), .overrun(ovrMsb));

   uart_if_nbyte #(.CLKS_PER_BIT(BIT), .WORD_BYTES(2), .MSB_FIRST(0), .TIMEOUT_BITS(8), .LOOPBACK(0)) dutLsb (
      .clk(clk), .rstb(rstb), .rxd(rxdMain), .txd(txdLsb), .rx_word(rxWordLsb), .rx_valid(rxValidLsb),
      .frame_err(feLsb), .tx_word(16'h0000), .tx_valid(1'b0), .tx_ready(txReadyLsb), .overrun(ovrLsb));

   // External tx_valid is held high here; loopback mode must ignore it.
   uart_if_nbyte #(.CLKS_PER_BIT(BIT), .WORD_BYTES(1), .MSB_FIRST(1), .TIMEOUT_BITS(8), .LOOPBACK(1)) dutLoop (
      .clk(clk), .rstb(rstb), .rxd(rxdLoop), .txd(txdLoop), .rx_word(rxWordLoop), .rx_valid(rxValidLoop),
      .frame_err(feLoop), .tx_word(8'hFF), .tx_valid(1'b1), .tx_ready(txReadyLoop), .overrun(ovrLoop));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic driveLine(input bit loopSel, input logic v, input int cycles);
      if (loopSel) rxdLoop = v;
      else rxdMain = v;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input bit stopOk, input bit loopSel, input int stopCycles);
      driveLine(loopSel, 1'b0, BIT);
      for (int b = 0; b < 8; b++) driveLine(loopSel, data[b], BIT);
      driveLine(loopSel, stopOk, stopCycles);
      if (!stopOk) driveLine(loopSel, 1'b1, 1);
   endtask

   task automatic idleBits(input bit loopSel, input int n);
      driveLine(loopSel, 1'b1, n * BIT);
   endtask

   task automatic txDecode(input bit loopSel);
      logic [7:0] data;
      logic stopBit;
      forever begin
         @(negedge clk);
         if (rstb && !(loopSel ? txdLoop : txdMsb)) begin
            repeat (BIT / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
               repeat (BIT) @(negedge clk);
               data[b] = loopSel ? txdLoop : txdMsb;
            end
            repeat (BIT) @(negedge clk);
            stopBit = loopSel ? txdLoop : txdMsb;
            if (txCheckOn) begin
               if (loopSel) begin
                  if (expLoopTxQ.size() == 0) begin
                     checks++; errors++;
                     $display("[TB] FAIL txLoopByte: got %0h expected no byte", data);
                  end else checkOutput("txLoopByte", {stopBit, data}, {1'b1, expLoopTxQ.pop_front()});
               end else begin
                  if (expTxQ.size() == 0) begin
                     checks++; errors++;
                     $display("[TB] FAIL txByte: got %0h expected no byte", data);
                  end else checkOutput("txByte", {stopBit, data}, {1'b1, expTxQ.pop_front()});
               end
            end
         end
      end
   endtask

   initial txDecode(1'b0);
   initial txDecode(1'b1);

   always @(negedge clk) begin
      if (rstb && rxValidMsb) begin
         if (expMsbQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL rxWordMsb: got %0h expected no word", rxWordMsb);
         end else checkOutput("rxWordMsb", rxWordMsb, expMsbQ.pop_front());
      end
      if (rstb && rxValidLsb) begin
         if (expLsbQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL rxWordLsb: got %0h expected no word", rxWordLsb);
         end else checkOutput("rxWordLsb", rxWordLsb, expLsbQ.pop_front());
      end
      if (rstb && rxValidLoop) begin
         if (expLoopRxQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL rxWordLoop: got %0h expected no word", rxWordLoop);
         end else checkOutput("rxWordLoop", rxWordLoop, expLoopRxQ.pop_front());
      end
      if (feMsb) feCountMsb++;
      if (feLsb) feCountLsb++;
      if (ovrLoop) ovrCountLoop++;
      if (ovrMsb) ovrCountMsb++;
   end

   initial begin
      int cnt;
      errors = 0; checks = 0;
      feCountMsb = 0; feCountLsb = 0; ovrCountLoop = 0; ovrCountMsb = 0;
      rstb = 1'b0; rxdMain = 1'b1; rxdLoop = 1'b1;
      txValid = 1'b0; txWord = '0; txCheckOn = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("resetTxd", txdMsb, 1'b1);
      checkOutput("resetTxReady", txReadyMsb, 1'b1);
      checkOutput("resetRxWord", rxWordMsb, 16'h0000);
      checkOutput("resetRxValid", rxValidMsb, 1'b0);
      checkOutput("resetFrameErr", feMsb, 1'b0);
      checkOutput("resetOverrun", ovrLoop, 1'b0);
      rstb = 1'b1;
      repeat (20) @(negedge clk);

      // Back-to-back bytes; both byte orders see the same line.
      expMsbQ.push_back(16'h596B); expLsbQ.push_back(16'h6B59);
      applyStimulus(8'h59, 1'b1, 1'b0, BIT);
      applyStimulus(8'h6B, 1'b1, 1'b0, BIT);
      idleBits(1'b0, 3);

      // Partial word 0x4D must time out during the 9-bit idle gap.
      expMsbQ.push_back(16'h2B11); expLsbQ.push_back(16'h112B);
      applyStimulus(8'h4D, 1'b1, 1'b0, BIT);
      idleBits(1'b0, 9);
      applyStimulus(8'h2B, 1'b1, 1'b0, BIT);
      applyStimulus(8'h11, 1'b1, 1'b0, BIT);
      idleBits(1'b0, 3);
      checkOutput("rxWordHeld", rxWordMsb, 16'h2B11);

      applyStimulus(8'h59, 1'b0, 1'b0, BIT);
      idleBits(1'b0, 2);
      checkOutput("rxWordHeldAfterFe", rxWordMsb, 16'h2B11);
      expMsbQ.push_back(16'h6B01); expLsbQ.push_back(16'h016B);
      applyStimulus(8'h6B, 1'b1, 1'b0, BIT);
      applyStimulus(8'h01, 1'b1, 1'b0, BIT);
      idleBits(1'b0, 3);

      // Transmit handshake; a request during busy must be ignored.
      expTxQ.push_back(8'hA5); expTxQ.push_back(8'hC3);
      txWord = 16'hA5C3; txValid = 1'b1;
      @(negedge clk);
      txValid = 1'b0;
      checkOutput("txStartBit", txdMsb, 1'b0);
      cnt = 0;
      while (!txReadyMsb && cnt < 3000) begin
         cnt++;
         if (cnt == 500) begin txWord = 16'h1234; txValid = 1'b1; end
         if (cnt == 501) txValid = 1'b0;
         @(negedge clk);
      end
      checkOutput("txReadyLow", cnt, 2160);
      repeat (200) @(negedge clk);
      checkOutput("txSecondIgnored", txReadyMsb, 1'b1);
      repeat (1200) @(negedge clk);
      checkOutput("txBytesPending", expTxQ.size(), 0);

      // Reset in the middle of a data bit must drive txd high without a clock edge.
      txCheckOn = 1'b0;
      txWord = 16'h00FF; txValid = 1'b1;
      @(negedge clk);
      txValid = 1'b0;
      repeat (300) @(negedge clk);
      checkOutput("txdMidFrame", txdMsb, 1'b0);
      #2 rstb = 1'b0;
      #1 checkOutput("txdAsyncReset", txdMsb, 1'b1);
      checkOutput("txReadyAsyncReset", txReadyMsb, 1'b1);
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      repeat (2000) @(negedge clk);
      txCheckOn = 1'b1;

      // Loopback: first byte echoes; the second completes mid-echo and overruns.
      expLoopRxQ.push_back(8'h3C); expLoopRxQ.push_back(8'h77);
      expLoopTxQ.push_back(8'h3C);
      applyStimulus(8'h3C, 1'b1, 1'b1, 80);
      applyStimulus(8'h77, 1'b1, 1'b1, BIT);
      idleBits(1'b1, 25);

      checkOutput("frameErrCountMsb", feCountMsb, 1);
      checkOutput("frameErrCountLsb", feCountLsb, 1);
      checkOutput("overrunCountLoop", ovrCountLoop, 1);
      checkOutput("overrunCountMsb", ovrCountMsb, 0);
      checkOutput("pendingMsb", expMsbQ.size(), 0);
      checkOutput("pendingLsb", expLsbQ.size(), 0);
      checkOutput("pendingLoopRx", expLoopRxQ.size(), 0);
      checkOutput("pendingLoopTx", expLoopTxQ.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
